dual_port_ram_be: RTL

//  Simple dual-port RAM (one write port, one read port, shared clock) with per-byte write enables.

---
 rtl/ram_pkg.sv | 17 +
 rtl/ram_clear_seq.sv | 35 +++
 rtl/dual_port_ram_be.sv | 81 ++++++++
 3 files changed

// File: rtl/ram_pkg.sv
// ram_pkg: read-mode constants, clear FSM state type and byte-lane merge helper
// shared by dual_port_ram_be and ram_clear_seq.
package ram_pkg;
    localparam int RD_OLD = 0;
    localparam int RD_NEW = 1;
    localparam int MAX_W = 1024;
    typedef enum logic {ST_CLEAR, ST_IDLE} state_t;
    function automatic logic [MAX_W-1:0] merge_be(input logic [MAX_W-1:0] old_w,
                                                  input logic [MAX_W-1:0] new_w,
                                                  input logic [MAX_W-1:0] be,
                                                  input int byte_w);
        logic [MAX_W-1:0] r;
        for (int b = 0; b < MAX_W; b++)
            r[b] = be[b / byte_w] ? new_w[b] : old_w[b];
        return r;
    endfunction
endpackage

// File: rtl/ram_clear_seq.sv
// ram_clear_seq: walks every address after reset or a clear request and
// drives the RAM write port with the init value while busy.
module ram_clear_seq
    import ram_pkg::*;
#(
    parameter int DEPTH = 256,
    parameter int AW = 8
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          clear,
    output logic          busy,
    output logic          clr_we,
    output logic [AW-1:0] clr_addr
);
    localparam logic [AW-1:0] LAST = AW'(DEPTH - 1);
    state_t state, state_nx;
    logic [AW-1:0] clr_cnt;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            state   <= ST_CLEAR;
            clr_cnt <= '0;
        end else begin
            state   <= state_nx;
            clr_cnt <= (state == ST_CLEAR) ? clr_cnt + 1'b1 : '0;
        end
    always_comb
        state_nx = (state == ST_CLEAR) ? ((clr_cnt == LAST) ? ST_IDLE : ST_CLEAR)
                                       : (clear ? ST_CLEAR : ST_IDLE);
    always_comb begin
        busy     = state == ST_CLEAR;
        clr_we   = busy;
        clr_addr = clr_cnt;
    end
endmodule

// File: rtl/dual_port_ram_be.sv
// dual_port_ram_be: simple dual-port RAM with byte-lane writes and a clear sequencer.
// Define RAM_OUTREG_EN to add an output register stage (read latency 2).
module dual_port_ram_be
    import ram_pkg::*;
#(
    parameter int SIZE = 32,
    parameter int DEPTH = 256,
    parameter int BYTE_W = 8,
    parameter int RD_MODE = RD_OLD,
    parameter logic [SIZE-1:0] INIT_VALUE = '0,
    localparam int NB = SIZE / BYTE_W,
    localparam int AW = DEPTH > 1 ? $clog2(DEPTH) : 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            wr_en,
    input  logic [AW-1:0]   wr_addr,
    input  logic [SIZE-1:0] wr_data,
    input  logic [NB-1:0]   wr_be,
    input  logic            rd_en,
    input  logic [AW-1:0]   rd_addr,
    output logic [SIZE-1:0] rd_data,
    output logic            rd_valid,
    input  logic            clear,
    output logic            busy
);
    if (SIZE % BYTE_W != 0 || SIZE > MAX_W) begin : g_bad_size
        $error("SIZE must be a multiple of BYTE_W and at most MAX_W");
    end
    logic [SIZE-1:0] mem [DEPTH];
    logic            clr_we, wr_ok, rd_ok, do_wr, do_rd, hit, rd_v;
    logic [AW-1:0]   clr_addr;
    logic [SIZE-1:0] rd_old, rd_next, rd_q;
    ram_clear_seq #(.DEPTH(DEPTH), .AW(AW)) u_seq (
        .clk(clk), .rst_n(rst_n), .clear(clear),
        .busy(busy), .clr_we(clr_we), .clr_addr(clr_addr)
    );
    // Requests arriving in the same cycle as a clear request are dropped.
    always_comb begin
        wr_ok   = {1'b0, wr_addr} < (AW+1)'(DEPTH);
        rd_ok   = {1'b0, rd_addr} < (AW+1)'(DEPTH);
        do_wr   = !busy && !clear && wr_en && wr_ok;
        do_rd   = !busy && !clear && rd_en;
        rd_old  = rd_ok ? mem[rd_addr] : '0;
        hit     = do_wr && rd_addr == wr_addr;
        rd_next = (RD_MODE == RD_NEW && hit)
                  ? SIZE'(merge_be(MAX_W'(rd_old), MAX_W'(wr_data), MAX_W'(wr_be), BYTE_W))
                  : rd_old;
    end
    always_ff @(posedge clk)
        if (clr_we)
            mem[clr_addr] <= INIT_VALUE;
        else if (do_wr)
            for (int i = 0; i < NB; i++)
                if (wr_be[i]) mem[wr_addr][i*BYTE_W +: BYTE_W] <= wr_data[i*BYTE_W +: BYTE_W];
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            rd_q <= '0;
            rd_v <= 1'b0;
        end else begin
            rd_v <= do_rd;
            if (do_rd) rd_q <= rd_next;
        end
`ifdef RAM_OUTREG_EN
    logic [SIZE-1:0] out_q;
    logic            out_v;
    always_ff @(posedge clk or negedge rst_n)
        if (!rst_n) begin
            out_q <= '0;
            out_v <= 1'b0;
        end else begin
            out_v <= rd_v;
            if (rd_v) out_q <= rd_q;
        end
    assign rd_data  = out_q;
    assign rd_valid = out_v;
`else
    assign rd_data  = rd_q;
    assign rd_valid = rd_v;
`endif
endmodule
